eq2_match_monitor_amisha: RTL

EQ2_MATCH_MONITOR_AMISHA -- requirements
Module: eq2_match_monitor_amisha

---
 rtl/eq2_amisha_pkg.sv | 13 +
 rtl/eq2_match_monitor_amisha_if.sv | 32 +++
 rtl/sat_cnt_amisha.sv | 26 ++
 rtl/eq2_match_monitor_amisha.sv | 123 ++++++++++++
 4 files changed

// File: rtl/eq2_amisha_pkg.sv
// Shared definitions for the eq2 match monitor: FSM state encodings and run width.
package eq2_amisha_pkg;

    localparam int unsigned RUN_W   = 4;
    localparam int unsigned STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE   = 2'd0,
        ST_TRACK  = 2'd1,
        ST_LOCKED = 2'd2
    } state_e;

endpackage

// File: rtl/eq2_match_monitor_amisha_if.sv
// Sample/result bundle for the eq2 match monitor.
//   master : drives clear/valid/a/b/aeqb, observes counters, run, lock, err, state
//   slave  : the monitor side (receives samples, drives results)
interface eq2_match_monitor_amisha_if
    import eq2_amisha_pkg::*;
#(
    parameter int unsigned CNT_W = 8
);
    logic               clear_amisha;
    logic               valid_amisha;
    logic [1:0]         a_amisha;
    logic [1:0]         b_amisha;
    logic               aeqb_amisha;
    logic [CNT_W-1:0]   match_cnt_amisha;
    logic [CNT_W-1:0]   mismatch_cnt_amisha;
    logic [RUN_W-1:0]   run_amisha;
    logic               lock_amisha;
    logic               err_amisha;
    logic [STATE_W-1:0] state_amisha;

    modport master (
        output clear_amisha, valid_amisha, a_amisha, b_amisha, aeqb_amisha,
        input  match_cnt_amisha, mismatch_cnt_amisha, run_amisha,
               lock_amisha, err_amisha, state_amisha
    );

    modport slave (
        input  clear_amisha, valid_amisha, a_amisha, b_amisha, aeqb_amisha,
        output match_cnt_amisha, mismatch_cnt_amisha, run_amisha,
               lock_amisha, err_amisha, state_amisha
    );
endinterface

// File: rtl/sat_cnt_amisha.sv
// Saturating up-counter with synchronous clear.
//   clk, rst_n : clock, synchronous active-low reset
//   clr        : zero the count (wins over inc)
//   inc        : add one, holding at all-ones
//   cnt        : registered count
module sat_cnt_amisha #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt
);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && (cnt != {CNT_W{1'b1}})) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/eq2_match_monitor_amisha.sv
// Monitors an upstream 2-bit equality comparator: counts matches/mismatches,
// tracks the consecutive-match run, locks after RUN_LEN matches in a row and
// flags any sample where aeqb disagrees with a==b.
//   clk_amisha     : clock, rising edge
//   reset_n_amisha : synchronous active-low reset
//   bus            : sample inputs and registered results (slave side)
module eq2_match_monitor_amisha
    import eq2_amisha_pkg::*;
#(
    parameter int unsigned RUN_LEN = 4,
    parameter int unsigned CNT_W   = 8
) (
    input  logic clk_amisha,
    input  logic reset_n_amisha,
    eq2_match_monitor_amisha_if.slave bus
);

    state_e           state_q, state_nxt;
    logic [RUN_W-1:0] run_q, run_nxt;
    logic             err_q, err_nxt;
    logic             lock_q;
    logic             accept_c;
    logic [CNT_W-1:0] match_cnt, mismatch_cnt;

    assign accept_c = bus.valid_amisha && !bus.clear_amisha;

    // State, run, err and lock registers
    always_ff @(posedge clk_amisha) begin
        if (!reset_n_amisha) begin
            state_q <= ST_IDLE;
            run_q   <= '0;
            err_q   <= 1'b0;
            lock_q  <= 1'b0;
        end else begin
            state_q <= state_nxt;
            run_q   <= run_nxt;
            err_q   <= err_nxt;
            lock_q  <= (state_nxt == ST_LOCKED);
        end
    end

    // Next-state, run length and sticky error
    always_comb begin
        state_nxt = state_q;
        run_nxt   = run_q;
        err_nxt   = err_q;

        if (bus.clear_amisha) begin
            state_nxt = ST_IDLE;
            run_nxt   = '0;
            err_nxt   = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.valid_amisha) begin
                        if (bus.aeqb_amisha) begin
                            run_nxt   = RUN_W'(1);
                            state_nxt = (RUN_LEN == 1) ? ST_LOCKED : ST_TRACK;
                        end else begin
                            run_nxt   = '0;
                            state_nxt = ST_TRACK;
                        end
                    end
                end
                ST_TRACK: begin
                    if (bus.valid_amisha) begin
                        if (bus.aeqb_amisha) begin
                            run_nxt = run_q + RUN_W'(1);
                            if ((run_q + RUN_W'(1)) == RUN_W'(RUN_LEN)) begin
                                state_nxt = ST_LOCKED;
                            end
                        end else begin
                            run_nxt = '0;
                        end
                    end
                end
                ST_LOCKED: begin
                    if (bus.valid_amisha) begin
                        if (bus.aeqb_amisha) begin
                            run_nxt = RUN_W'(RUN_LEN);
                        end else begin
                            run_nxt   = '0;
                            state_nxt = ST_TRACK;
                        end
                    end
                end
                default: begin
                    // Unused encoding 3: fall back to IDLE unconditionally
                    state_nxt = ST_IDLE;
                    run_nxt   = '0;
                end
            endcase

            if (accept_c && (bus.aeqb_amisha != (bus.a_amisha == bus.b_amisha))) begin
                err_nxt = 1'b1;
            end
        end
    end

    sat_cnt_amisha #(.CNT_W(CNT_W)) u_match_cnt (
        .clk   (clk_amisha),
        .rst_n (reset_n_amisha),
        .clr   (bus.clear_amisha),
        .inc   (accept_c && bus.aeqb_amisha),
        .cnt   (match_cnt)
    );

    sat_cnt_amisha #(.CNT_W(CNT_W)) u_mismatch_cnt (
        .clk   (clk_amisha),
        .rst_n (reset_n_amisha),
        .clr   (bus.clear_amisha),
        .inc   (accept_c && !bus.aeqb_amisha),
        .cnt   (mismatch_cnt)
    );

    assign bus.match_cnt_amisha    = match_cnt;
    assign bus.mismatch_cnt_amisha = mismatch_cnt;
    assign bus.run_amisha          = run_q;
    assign bus.lock_amisha         = lock_q;
    assign bus.err_amisha          = err_q;
    assign bus.state_amisha        = state_q;

endmodule
